// File: rtl/q_meas_sequencer_pkg.sv
// Shared definitions for the Q-tuning measurement path.
// The secant solver imports this package as well.
//   state_t       : sequencer state encoding
//   Q_TOL_DEFAULT : default convergence tolerance on |Q - desired|
//   err_w()       : width of the signed |a-b| datapath (one bit wider than the
//                   operands, so that max-min cannot wrap)
package q_meas_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_REQ,
    S_LOAD,
    S_SETTLE,
    S_MEASURE,
    S_REPORT,
    S_DONE
  } state_t;

  localparam int Q_TOL_DEFAULT = 30;

  function automatic int err_w(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/q_meas_sequencer_if.sv
// Solver <-> sequencer handshake.
//   req_valid/i_ref_req : solver offers the next I_REF code
//   req_ready           : sequencer can take a request
//   q_out/q_ready       : measured Q, with a one-cycle valid pulse
// master = solver side, slave = sequencer side.
interface q_meas_sequencer_if #(
  parameter int WIDTH = 10
);
  logic             req_valid;
  logic [WIDTH-1:0] i_ref_req;
  logic             req_ready;
  logic [WIDTH-1:0] q_out;
  logic             q_ready;

  modport master (output req_valid, i_ref_req, input req_ready, q_out, q_ready);
  modport slave  (input req_valid, i_ref_req, output req_ready, q_out, q_ready);
endinterface

// File: rtl/q_meas_sequencer_q_err_check.sv
// Combinational tolerance check: within_tol = |a - b| < TOL.
// Operands are unsigned; the difference is formed one bit wider and signed, so
// the magnitude never wraps (0 vs 2^WIDTH-1 gives 2^WIDTH-1).
//   a, b       : WIDTH-bit unsigned operands
//   within_tol : 1 when the absolute difference is strictly below TOL
module q_err_check
  import q_meas_sequencer_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int TOL   = Q_TOL_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             within_tol
);
  localparam int EW = err_w(WIDTH);

  logic signed [EW-1:0] diff;
  logic        [EW-1:0] mag;

  always_comb begin
    diff       = $signed({1'b0, a}) - $signed({1'b0, b});
    mag        = diff[EW-1] ? $unsigned(-diff) : $unsigned(diff);
    within_tol = (mag < EW'(TOL));
  end
endmodule

// File: rtl/q_meas_sequencer.sv
// One Q-tuning measurement per solver request:
//   accept I_REF -> load DAC -> settle -> trigger measurement -> report Q.
// Ends the run on tolerance, iteration cap, or measurement timeout.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   start, desired_q    : begin a run (IDLE only), target Q
//   sbus                : solver handshake (request in, q_out/q_ready out)
//   dac_code, dac_load  : bias DAC code and one-cycle strobe
//   meas_start          : one-cycle measurement trigger
//   meas_done, meas_q   : front-end result
//   busy, done          : run status (done holds until next start)
//   converged, timeout_err : run outcome, valid with done
//   iter_cnt            : measurements completed this run
module q_meas_sequencer
  import q_meas_sequencer_pkg::*;
#(
  parameter int WIDTH         = 10,
  parameter int TOL           = Q_TOL_DEFAULT,
  parameter int SETTLE_CYCLES = 16,
  parameter int MEAS_TIMEOUT  = 1024,
  parameter int MAX_ITER      = 32,
  parameter int CNT_W         = 11,
  localparam int IT_W         = $clog2(MAX_ITER + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  desired_q,
  q_meas_sequencer_if.slave sbus,
  output logic [WIDTH-1:0]  dac_code,
  output logic              dac_load,
  output logic              meas_start,
  input  logic              meas_done,
  input  logic [WIDTH-1:0]  meas_q,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic              timeout_err,
  output logic [IT_W-1:0]   iter_cnt
);

  state_t           state;
  logic [WIDTH-1:0] des_q;
  logic [CNT_W-1:0] cnt;   // settle count, then reused as timeout count
  logic             in_tol;

  // Evaluated in REPORT, where q_out already holds the captured sample.
  q_err_check #(.WIDTH(WIDTH), .TOL(TOL)) u_err (
    .a         (sbus.q_out),
    .b         (des_q),
    .within_tol(in_tol)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      des_q          <= '0;
      cnt            <= '0;
      dac_code       <= '0;
      dac_load       <= 1'b0;
      meas_start     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      converged      <= 1'b0;
      timeout_err    <= 1'b0;
      iter_cnt       <= '0;
      sbus.req_ready <= 1'b0;
      sbus.q_out     <= '0;
      sbus.q_ready   <= 1'b0;
    end else begin
      // Strobes are single-cycle by default.
      dac_load     <= 1'b0;
      meas_start   <= 1'b0;
      sbus.q_ready <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          des_q          <= desired_q;
          iter_cnt       <= '0;
          done           <= 1'b0;
          converged      <= 1'b0;
          timeout_err    <= 1'b0;
          busy           <= 1'b1;
          sbus.req_ready <= 1'b1;
          state          <= S_WAIT_REQ;
        end
        S_WAIT_REQ: if (sbus.req_valid) begin
          dac_code       <= sbus.i_ref_req;
          sbus.req_ready <= 1'b0;
          dac_load       <= 1'b1;
          state          <= S_LOAD;
        end
        S_LOAD: begin
          cnt   <= CNT_W'(SETTLE_CYCLES);
          state <= S_SETTLE;
        end
        // meas_done is deliberately ignored while settling.
        S_SETTLE: begin
          if (cnt == CNT_W'(1)) begin
            meas_start <= 1'b1;
            cnt        <= CNT_W'(MEAS_TIMEOUT);
            state      <= S_MEASURE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // A result in the last counted cycle still wins; the cycle after
        // expiry is already DONE, so a late meas_done is dropped.
        S_MEASURE: begin
          if (meas_done) begin
            sbus.q_out <= meas_q;
            iter_cnt   <= iter_cnt + 1'b1;
            state      <= S_REPORT;
          end else if (cnt == CNT_W'(1)) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // q_ready is registered out of REPORT, landing two cycles after
        // meas_done and alongside req_ready (continue) or done (finish).
        S_REPORT: begin
          sbus.q_ready <= 1'b1;
          if (in_tol || iter_cnt == IT_W'(MAX_ITER)) begin
            converged <= in_tol;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= S_DONE;
          end else begin
            sbus.req_ready <= 1'b1;
            state          <= S_WAIT_REQ;
          end
        end
        // busy already dropped on entry; start is not sampled here.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_q_meas_sequencer.sv
module tb_q_meas_sequencer;
  localparam int W        = 10;
  localparam int TOL      = 30;
  localparam int SETTLE   = 16;
  localparam int MEAS_TO  = 1024;
  localparam int MAX_ITER = 4;
  localparam int IT_W     = $clog2(MAX_ITER + 1);

  logic            clk, rst, start, meas_done;
  logic [W-1:0]    desired_q, meas_q, dac_code;
  logic            dac_load, meas_start, busy, done, converged, timeout_err;
  logic [IT_W-1:0] iter_cnt;

  q_meas_sequencer_if #(.WIDTH(W)) bus ();

  q_meas_sequencer #(
    .WIDTH(W), .TOL(TOL), .SETTLE_CYCLES(SETTLE), .MEAS_TIMEOUT(MEAS_TO),
    .MAX_ITER(MAX_ITER), .CNT_W(11)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .desired_q(desired_q), .sbus(bus),
    .dac_code(dac_code), .dac_load(dac_load), .meas_start(meas_start),
    .meas_done(meas_done), .meas_q(meas_q), .busy(busy), .done(done),
    .converged(converged), .timeout_err(timeout_err), .iter_cnt(iter_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0, qr_cnt = 0;
  int resp[$];

  always @(posedge clk) if (bus.q_ready === 1'b1) qr_cnt <= qr_cnt + 1;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // One run: desired value des, responses from resp[]; iteration to_idx never
  // gets meas_done, iteration rst_idx is hit by reset mid-settle (-1 = none).
  task automatic run(input int des, input int to_idx, input int rst_idx);
    int k, n, d, v, ir, q0, qc, err;
    bit stop, conv;
    start = 1'b1; desired_q = W'(des); step(); start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_req_ready", bus.req_ready, 1);
    chk("start_done_clr", done, 0);
    chk("start_iter_clr", iter_cnt, 0);
    k = 0; stop = 0;
    while (!stop) begin
      ir = $urandom_range(0, 1023);
      bus.i_ref_req = W'(ir); bus.req_valid = 1'b1;
      step();
      chk("dac_load", dac_load, 1);
      chk("dac_code", dac_code, ir);
      chk("req_ready_low", bus.req_ready, 0);
      bus.i_ref_req = W'(ir ^ 'h155);  // stray request held outside WAIT_REQ
      n = 0;
      do begin
        step(); n++;
        if (n == 1) chk("dac_load_pulse", dac_load, 0);
        if (n == 3) begin meas_done = 1'b1; meas_q = 10'd777; start = 1'b1; end
        if (n == 4) begin meas_done = 1'b0; start = 1'b0; end
        if (k == rst_idx && n == 8) begin
          rst = 1'b0; #1;
          chk("rst_busy", busy, 0);
          chk("rst_dac_code", dac_code, 0);
          chk("rst_q_out", bus.q_out, 0);
          chk("rst_iter", iter_cnt, 0);
          chk("rst_strobes", {dac_load, meas_start, bus.q_ready, bus.req_ready}, 0);
          chk("rst_status", {done, converged, timeout_err}, 0);
          repeat (2) step();
          rst = 1'b1;  // req_valid still high: must be ignored in IDLE
          repeat (4) step();
          chk("idle_req_ignored", {bus.req_ready, dac_load, busy, dac_code}, 0);
          bus.req_valid = 1'b0;
          return;
        end
      end while (!meas_start && n < 40);
      bus.req_valid = 1'b0;
      chk("settle_latency", n, SETTLE + 1);
      chk("stray_req_ignored", dac_code, ir);
      chk("settle_iter", iter_cnt, k);
      if (k == to_idx) begin
        q0 = bus.q_out; qc = qr_cnt; n = 0;
        do begin step(); n++; end while (!done && n < 2000);
        chk("timeout_latency", n, MEAS_TO);
        meas_done = 1'b1; meas_q = 10'd3;   // one cycle after expiry
        step(); meas_done = 1'b0;
        chk("to_err", timeout_err, 1);
        chk("to_conv", converged, 0);
        chk("to_q_out", bus.q_out, q0);
        chk("to_iter", iter_cnt, k);
        chk("to_no_q_ready", qr_cnt, qc);
        chk("to_done_idle", {done, busy}, 2'b10);
        return;
      end
      d = $urandom_range(0, 5);
      for (int i = 0; i < d; i++) begin
        step();
        if (i == 0) chk("meas_start_pulse", meas_start, 0);
      end
      v = resp[k];
      meas_done = 1'b1; meas_q = W'(v);
      step();
      meas_done = 1'b0; meas_q = W'($urandom);
      chk("q_ready_early", bus.q_ready, 0);
      step();
      k++;
      err  = absdiff(v, des);
      conv = (err < TOL);
      stop = conv || (k == MAX_ITER);
      chk("q_ready", bus.q_ready, 1);
      chk("q_out", bus.q_out, v);
      chk("iter_cnt", iter_cnt, k);
      chk("done", done, stop);
      chk("req_ready_again", bus.req_ready, !stop);
      chk("converged", converged, stop && conv);
      chk("timeout_err", timeout_err, 0);
    end
    start = 1'b1;  // start in the DONE cycle: ignored
    step(); start = 1'b0;
    chk("end_idle", {busy, bus.req_ready, bus.q_ready}, 0);
    chk("end_done_hold", done, 1);
    chk("end_iter_hold", iter_cnt, k);
  endtask

  initial begin
    int des;
    rst = 1'b0; start = 1'b0; meas_done = 1'b0; meas_q = '0; desired_q = '0;
    bus.req_valid = 1'b0; bus.i_ref_req = '0;
    #3;
    chk("reset_outputs", {dac_code, dac_load, meas_start, busy, done, converged,
                          timeout_err, bus.req_ready, bus.q_ready}, 0);
    chk("reset_q_iter", {bus.q_out, iter_cnt}, 0);
    step(); rst = 1'b1; step();

    resp = '{510};            run(500, -1, -1);   // basic
    resp = '{200, 400, 495};  run(500, -1, -1);   // multi-iteration
    resp = '{0, 0, 0, 0};     run(500, -1, -1);   // iteration cap
    resp = '{100};            run(500,  1, -1);   // timeout on 2nd measurement
    resp = '{0};              run(500, -1,  1);   // reset mid-settle
    resp = '{1023, 0, 1, 1};  run(0,   -1, -1);   // no wrap on max error
    resp = '{1};              run(30,  -1, -1);   // err 29
    resp = '{0, 31};          run(30,  -1, -1);   // err 30, then 1
    for (int r = 0; r < 5; r++) begin
      des = $urandom_range(0, 1023);
      resp.delete();
      for (int i = 0; i < MAX_ITER; i++) begin
        int v;
        v = des + int'($urandom_range(0, 120)) - 60;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        resp.push_back(v);
      end
      run(des, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
